// File: rtl/flap_game_ctrl_if.sv
// Bundle between the playfield/timer logic and the game controller.
// The master side drives the event inputs; the slave side is the controller.
interface flap_game_ctrl_if;
  logic        start_btn;
  logic        pipe_pass;
  logic        collision;
  logic        time_up;
  logic [1:0]  state;
  logic        playing;
  logic        game_over;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        new_high;

  modport master (
    output start_btn, pipe_pass, collision, time_up,
    input  state, playing, game_over, score_bcd, high_bcd, new_high
  );

  modport slave (
    input  start_btn, pipe_pass, collision, time_up,
    output state, playing, game_over, score_bcd, high_bcd, new_high
  );
endinterface

// File: rtl/flap_game_ctrl.sv
// Flappy-bird game-state FSM with a saturating 4-digit BCD score and a
// high-score register; the raw start button is synchronised internally.
module flap_game_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [15:0] SCORE_MAX_BCD = 16'h9999
) (
  input logic            clock_100Mhz,
  input logic            reset,
  flap_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t                 st;
  logic [SYNC_STAGES-1:0] sync;
  logic                   start_d;
  logic                   start_rise;
  logic [15:0]            score;
  logic [15:0]            high;
  logic                   new_high;
  logic [15:0]            score_inc;

  // Digit-wise increment with rippling carry; callers gate it at saturation.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = '0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign score_inc  = bcd_inc(score);
  assign start_rise = sync[SYNC_STAGES-1] & ~start_d;

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      sync    <= '0;
      start_d <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], bus.start_btn};
      start_d <= sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      score    <= '0;
      high     <= '0;
      new_high <= 1'b0;
    end else begin
      new_high <= 1'b0;
      case (st)
        IDLE: begin
          if (start_rise) begin
            st    <= PLAY;
            score <= '0;
          end
        end
        PLAY: begin
          // End of round wins over a same-cycle pipe_pass, which is dropped.
          if (bus.collision || bus.time_up) begin
            st <= OVER;
            if (score > high) begin
              high     <= score;
              new_high <= 1'b1;
            end
          end else if (bus.pipe_pass && (score != SCORE_MAX_BCD)) begin
            score <= score_inc;
          end
        end
        OVER: begin
          if (start_rise) begin
            st    <= IDLE;
            score <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.state     = st;
  assign bus.playing   = (st == PLAY);
  assign bus.game_over = (st == OVER);
  assign bus.score_bcd = score;
  assign bus.high_bcd  = high;
  assign bus.new_high  = new_high;

endmodule

// File: tb/tb_flap_game_ctrl.sv
// Scoreboard bench for flap_game_ctrl: a driver steps an integer-level game
// model and queues expected outputs; a monitor pops and compares each cycle.
module tb_flap_game_ctrl;

  logic clk;
  logic rst_n;

  flap_game_ctrl_if bus();

  flap_game_ctrl #(
    .SYNC_STAGES   (2),
    .SCORE_MAX_BCD (16'h9999)
  ) dut (
    .clock_100Mhz (clk),
    .reset        (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] hi;
    logic        nh;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  // Reference model: state 0 idle, 1 play, 2 over; scores as plain integers.
  int m_st;
  int m_score;
  int m_high;
  bit m_nh;
  bit hist [3];   // start_btn sampled 1, 2, 3 edges ago

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void model_reset();
    m_st = 0; m_score = 0; m_high = 0; m_nh = 0;
    hist[0] = 0; hist[1] = 0; hist[2] = 0;
  endfunction

  function automatic void model_step(input bit btn, input bit pp, input bit col, input bit tu);
    bit rise;
    rise = hist[1] && !hist[2];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btn;
    m_nh = 0;
    if (m_st == 0) begin
      if (rise) begin m_st = 1; m_score = 0; end
    end else if (m_st == 1) begin
      if (col || tu) begin
        m_st = 2;
        if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
      end else if (pp && m_score < 9999) begin
        m_score++;
      end
    end else begin
      if (rise) begin m_st = 0; m_score = 0; end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.st = 2'(m_st);
    e.sc = to_bcd(m_score);
    e.hi = to_bcd(m_high);
    e.nh = m_nh;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input bit btn, input bit pp, input bit col, input bit tu);
    @(negedge clk);
    bus.start_btn = btn; bus.pipe_pass = pp; bus.collision = col; bus.time_up = tu;
    if (rst_n) model_step(btn, pp, col, tu);
    push_exp();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    push_exp();
    for (int i = 1; i < n; i++) cyc(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.start_btn = 0; bus.pipe_pass = 0; bus.collision = 0; bus.time_up = 0;
    model_step(0, 0, 0, 0);
    push_exp();
  endtask

  task automatic press();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every output is registered, so sample just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",     16'(bus.state),     16'(e.st));
        chk("playing",   16'(bus.playing),   16'(e.st == 2'b01));
        chk("game_over", 16'(bus.game_over), 16'(e.st == 2'b10));
        chk("score_bcd", bus.score_bcd,      e.sc);
        chk("high_bcd",  bus.high_bcd,       e.hi);
        chk("new_high",  16'(bus.new_high),  16'(e.nh));
      end
    end
  end

  initial begin
    tests = 0; fails = 0;
    bus.start_btn = 0; bus.pipe_pass = 0; bus.collision = 0; bus.time_up = 0;
    rst_n = 1'b1;
    model_reset();
    do_reset(3);

    // Mid-play reset with score 0042, then events while idle are ignored.
    press();
    pulses(42);
    do_reset(2);
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Start held for 50 cycles: exactly one transition.
    for (int i = 0; i < 50; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

    // Score 7 then pipe_pass and collision together.
    pulses(7);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);

    // Ignored events in OVER.
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 1, 1, 1); cyc(0, 0, 0, 0);

    // Lower score 5 ends by time_up; then an equal score 7.
    press(); press(); pulses(5); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    press(); press(); pulses(7); cyc(0, 0, 1, 1); cyc(0, 0, 0, 0);

    // Back to idle and hold time_up there.
    press();
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    // Carry and saturation: 99, 999, then 9999 plus two extra.
    press();
    pulses(99);
    pulses(900);
    pulses(9002);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Randomised play.
    for (int i = 0; i < 4000; i++) begin
      bit btn, pp, col, tu;
      btn = ($urandom_range(0, 29) < 4);
      pp  = ($urandom_range(0, 2) == 0);
      col = ($urandom_range(0, 59) == 0);
      tu  = ($urandom_range(0, 99) == 0);
      if (i == 2000) do_reset(2);
      cyc(btn, pp, col, tu);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
